// File: rtl/tpu_fixed_pkg.sv
// Fixed-point types and limits shared by the MAC accumulator and the int18-to-bf16 normalizer.
package tpu_fixed_pkg;

    localparam int DATA_W    = 8;
    localparam int ACC_W     = 18;
    localparam int FRAC_BITS = 8;
    localparam int CNT_W     = 8;
    localparam int PROD_W    = 2 * DATA_W;

    localparam logic [ACC_W-1:0] ACC_MAX = 18'h1FFFF;
    localparam logic [ACC_W-1:0] ACC_MIN = 18'h20000;

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [DATA_W-1:0] opnd_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/sat_add.sv
// Signed accumulator add of a narrower sign-extended addend, clamped to the acc_t range.
module sat_add
    import tpu_fixed_pkg::*;
#(
    parameter int ADD_W = PROD_W
) (
    input  acc_t                    acc_in,
    input  logic signed [ADD_W-1:0] addend,
    output acc_t                    sum,
    output logic                    ovf
);

    logic [ACC_W:0] wide;

    always_comb begin
        wide = {acc_in[ACC_W-1], acc_in} + {{(ACC_W + 1 - ADD_W){addend[ADD_W-1]}}, addend};
        // The two top bits disagree only when the true sum left the ACC_W range.
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];
        if (!ovf) begin
            sum = wide[ACC_W-1:0];
        end else if (wide[ACC_W]) begin
            sum = ACC_MIN;
        end else begin
            sum = ACC_MAX;
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Two-stage Q4.4 multiply / Q10.8 saturating accumulate, one registered result per vector.
// State | meaning: SLOT_EMPTY | no result held; SLOT_FULL | result waiting for out_ready.
module mac_accumulator
    import tpu_fixed_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_sat,
    output logic [CNT_W-1:0]  out_count
);

    prod_t             p_prod_q, p_prod_d;
    logic              p_valid_q, p_valid_d;
    logic              p_last_q, p_last_d;
    acc_t              acc_q, acc_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    acc_t              out_acc_q, out_acc_d;
    logic              out_sat_q, out_sat_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    slot_state_e       slot_q, slot_d;

    acc_t              sum;
    logic              ovf;
    logic              out_free;
    logic              p_consume;
    logic              in_fire;
    logic              load;
    logic [CNT_W-1:0]  cnt_inc;
    prod_t             a_ext;
    prod_t             b_ext;

    sat_add #(.ADD_W(PROD_W)) u_sat_add (
        .acc_in (acc_q),
        .addend (p_prod_q),
        .sum    (sum),
        .ovf    (ovf)
    );

    assign out_valid = (slot_q == SLOT_FULL);
    assign out_acc   = out_acc_q;
    assign out_sat   = out_sat_q;
    assign out_count = out_cnt_q;

    always_comb begin
        out_free  = !out_valid || out_ready;
        // Only a last product needs the output slot; partial sums never stall.
        p_consume = p_valid_q && (!p_last_q || out_free);
        in_ready  = !p_valid_q || p_consume;
        in_fire   = in_valid && in_ready;
        load      = p_consume && p_last_q;
        cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        a_ext     = prod_t'(opnd_t'(in_a));
        b_ext     = prod_t'(opnd_t'(in_b));

        p_prod_d  = p_prod_q;
        p_valid_d = p_valid_q;
        p_last_d  = p_last_q;
        acc_d     = acc_q;
        sat_d     = sat_q;
        cnt_d     = cnt_q;
        out_acc_d = out_acc_q;
        out_sat_d = out_sat_q;
        out_cnt_d = out_cnt_q;
        slot_d    = slot_q;

        if (in_fire) begin
            p_prod_d  = a_ext * b_ext;
            p_valid_d = 1'b1;
            p_last_d  = in_last;
        end else if (p_consume) begin
            p_valid_d = 1'b0;
        end

        if (p_consume) begin
            if (p_last_q) begin
                out_acc_d = sum;
                out_sat_d = sat_q | ovf;
                out_cnt_d = cnt_inc;
                acc_d     = '0;
                sat_d     = 1'b0;
                cnt_d     = '0;
            end else begin
                acc_d = sum;
                sat_d = sat_q | ovf;
                cnt_d = cnt_inc;
            end
        end

        case (slot_q)
            SLOT_EMPTY: if (load) slot_d = SLOT_FULL;
            SLOT_FULL:  if (out_ready && !load) slot_d = SLOT_EMPTY;
            default:    slot_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_prod_q  <= '0;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            cnt_q     <= '0;
            out_acc_q <= '0;
            out_sat_q <= 1'b0;
            out_cnt_q <= '0;
            slot_q    <= SLOT_EMPTY;
        end else begin
            p_prod_q  <= p_prod_d;
            p_valid_q <= p_valid_d;
            p_last_q  <= p_last_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            cnt_q     <= cnt_d;
            out_acc_q <= out_acc_d;
            out_sat_q <= out_sat_d;
            out_cnt_q <= out_cnt_d;
            slot_q    <= slot_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed-vector bench for mac_accumulator with hand-computed expected results.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_acc;
    logic        out_sat;
    logic [7:0]  out_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [17:0] q_acc[$];
    logic        q_sat[$];
    logic [7:0]  q_cnt[$];

    always #5 clk = ~clk;

    mac_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Capture every accepted result.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready) begin
                q_acc.push_back(out_acc);
                q_sat.push_back(out_sat);
                q_cnt.push_back(out_count);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_vec(input logic [7:0] a, input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send(a, b, i == n - 1);
    endtask

    task automatic get_result(input string tag, input logic [17:0] e_acc,
                              input logic e_sat, input logic [7:0] e_cnt);
        for (int i = 0; i < 100 && q_acc.size() == 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (q_acc.size() == 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_acc"}, q_acc.pop_front(), e_acc);
            chk({tag, "_sat"}, q_sat.pop_front(), e_sat);
            chk({tag, "_cnt"}, q_cnt.pop_front(), e_cnt);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_acc",   out_acc,   0);
        chk("rst_out_sat",   out_sat,   0);
        chk("rst_out_count", out_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1.0 * 1.0, four terms
        send_vec(8'h10, 8'h10, 4);
        idle();
        #1;
        chk("lat_edge1_valid", out_valid, 0);
        @(negedge clk);
        #1;
        chk("lat_edge2_valid", out_valid, 1);
        get_result("t1", 18'h00400, 1'b0, 8'd4);

        send_vec(8'h7F, 8'h7F, 9);
        idle();
        get_result("t2_pos_sat", 18'h1FFFF, 1'b1, 8'd9);

        send_vec(8'h80, 8'h7F, 9);
        idle();
        get_result("t3_neg_sat", 18'h20000, 1'b1, 8'd9);
        send_vec(8'h80, 8'h80, 1);
        idle();
        get_result("t3_clean", 18'h04000, 1'b0, 8'd1);

        // Two 2-beat vectors against a blocked output slot
        @(negedge clk);
        out_ready = 1'b0;
        send(8'h10, 8'h20, 1'b0);
        send(8'h08, 8'h10, 1'b1);
        send(8'hF0, 8'h10, 1'b0);
        send(8'h30, 8'h10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            #1;
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_acc",   out_acc,   18'h00280);
            chk("t4_in_ready",   in_ready,  0);
        end
        chk("t4_none_early", q_acc.size(), 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("t4_second_valid", out_valid, 1);
        chk("t4_second_acc",   out_acc,   18'h00200);
        get_result("t4_first",  18'h00280, 1'b0, 8'd2);
        get_result("t4_second", 18'h00200, 1'b0, 8'd2);

        send_vec(8'h00, 8'h00, 300);
        idle();
        get_result("t5_cnt_sat", 18'h00000, 1'b0, 8'd255);

        // Reset in the middle of a vector
        send_vec(8'h10, 8'h10, 3);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_in_ready",  in_ready,  1);
        send(8'h20, 8'h08, 1'b1);
        idle();
        repeat (10) @(negedge clk);
        #2;
        chk("t6_one_result", q_acc.size(), 1);
        get_result("t6", 18'h00100, 1'b0, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential multiply-accumulate stage that sits directly upstream of the int18-to-bf16 normalizer. It accepts a stream of signed Q4.4 operand pairs under a valid/ready handshake and accumulates their Q8.8 products into a saturating 18-bit Q10.8 accumulator. On the last beat of a vector it emits one registered 18-bit result, with a sticky saturation flag and a term count, to the normalizer under a second valid/ready handshake.

## Interface
- DATA_W, 8, operand width, signed Q4.4
- ACC_W, 18, accumulator/result width, signed Q10.8; must equal the normalizer input width
- CNT_W, 8, term counter width
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept a beat
- in_a  in  DATA_W  signed operand A
- in_b  in  DATA_W  signed operand B
- in_last  in  1  final beat of the current vector
- out_valid  out  1  result held in output register
- out_ready  in  1  downstream accepts result
- out_acc  out  ACC_W  signed Q10.8 dot-product result
- out_sat  out  1  saturation occurred at any point in this vector
- out_count  out  CNT_W  number of terms in vector, saturating at 2^CNT_W-1

## Operation
- Beat accepted when in_valid && in_ready.
- Stage P (product register): p_prod = in_a*in_b, 16-bit signed, Q8.8; p_valid and p_last registered with it.
- Stage A (accumulate): sum = sign-extended acc + sign-extended p_prod, computed at ACC_W+1 bits.
  - sum > 2^(ACC_W-1)-1: clamp to 0x1FFFF and set sticky sat.
  - sum < -2^(ACC_W-1): clamp to 0x20000 and set sticky sat.
- Count increments per consumed product, saturating at 255.
- When p_last is consumed:
  - The clamped sum, sat (including this beat) and count load into the output register; out_valid is set.
  - acc, sat and count clear to 0 in the same edge, so the next vector starts clean with no idle cycle.
- A single-beat vector (in_last on the first beat) is legal and yields count=1.
- Stall: a last product cannot be consumed while out_valid && !out_ready.
  - p stage holds; in_ready = !p_valid || p_consumable.
  - A non-last product is always consumable.
- The output register is released on out_valid && out_ready. A new result may load in that same edge, giving back-to-back results.
- Outputs stay stable while out_valid && !out_ready.
- FSM (output slot): EMPTY -> FULL on last-product consume; FULL -> EMPTY on accept with no new load; FULL -> FULL on accept with a simultaneous load.

## Timing
- Reset values: in_ready=1, out_valid=0, out_acc=0, out_sat=0, out_count=0. Internal acc, sat, count and p_valid are also cleared.
- rst mid-vector or with a result pending discards all partial and held data; no output is produced for that vector.
- Latency: last beat accepted at edge N, product registered at N, accumulated at N+1, out_valid high after edge N+1, i.e. 2 cycles from beat presentation.
- Throughput: 1 beat/cycle while the output slot does not block.
- in_ready is combinational from p_valid, p_last, out_valid and out_ready. There is no path from in_valid to in_ready.

## Structure
- Shared package tpu_fixed_pkg holds:
  - ACC_W, FRAC_BITS=8, DATA_W
  - ACC_MAX=18'h1FFFF and ACC_MIN=18'h20000
  - typedefs acc_t (signed [17:0]) and opnd_t (signed [7:0])
- The normalizer imports the same package.
- One sub-module, sat_add: combinational signed ACC_W add of a sign-extended addend, with clamped result and overflow flag.

## Test plan
- 0x10*0x10 ×4 with last on beat 4 -> out_acc=0x00400 (4.0), sat=0, count=4; out_valid exactly 2 cycles after the last beat.
- 0x7F*0x7F ×9 (16129 each, total 145161) -> out_acc=0x1FFFF, sat=1, count=9.
- 0x80*0x7F ×9 (-16256 each) -> out_acc=0x20000, sat=1. Then a following vector 0x80*0x80 ×1 -> 0x04000, sat=0, count=1 (sticky flags cleared).
- Two back-to-back 2-beat vectors, out_ready=0 for 5 cycles -> first result held stable, in_ready drops once the second last product is pending, second result appears the cycle after the first is accepted, no beats lost.
- 300 beats of 0x00*0x00 -> out_acc=0, count=255 (saturated), sat=0.
- rst asserted for one cycle after 3 beats, then a 1-beat vector 0x20*0x08 -> only one result: out_acc=0x00100, count=1.
